// File: rtl/dynamic_output_rr_para.sv
// Round-robin wormhole output port: NUM_IN channels onto one credited link, with a registered output stage.
// Optional perf counters are built when DYNAMIC_OUTPUT_PERF_CNT_EN is defined.
module dynamic_output_rr_para #(
  parameter int unsigned NUM_IN       = 5,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned CREDITS      = 4,
  parameter int unsigned KILL_HEADERS = 0,
  parameter int unsigned LEN_LSB      = 22,
  parameter int unsigned LEN_W        = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            route_req_in,
  input  logic [NUM_IN-1:0]            tail_in,
  input  logic [NUM_IN-1:0]            valid_in,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
  input  logic                         yummy_in,
  output logic [NUM_IN-1:0]            thanks_out,
  output logic                         valid_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         popped_zero_len_mesg_out,
  output logic                         ec_wants_to_send_but_cannot,
  output logic [15:0]                  perf_flits_out,
  output logic [15:0]                  perf_stall_out
);

  localparam int unsigned CUR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned CRED_W = $clog2(CREDITS + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CUR_W-1:0]    r_cur;
  logic [CUR_W-1:0]    w_cur_nxt;
  logic [CUR_W-1:0]    r_rr_ptr;
  logic [CUR_W-1:0]    w_rr_nxt;
  logic [CRED_W-1:0]   r_credit_cnt;
  logic                r_valid_out;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic [NUM_IN-1:0]   w_cand;
  logic                w_any_cand;
  logic [CUR_W-1:0]    w_winner;
  logic [CUR_W-1:0]    w_cur;
  logic [CUR_W-1:0]    w_cur_inc;
  logic                w_granted;
  logic                w_cur_valid;
  logic                w_cur_tail;
  logic [DATA_WIDTH-1:0] w_cur_flit;
  logic                w_kill;
  logic                w_send;
  logic                w_fwd;
  logic                w_ec;
  logic                w_len_zero;

  assign w_cand = route_req_in & valid_in;

  // First candidate at or after rr_ptr, wrapping; scanning downward lets the nearest one win.
  always_comb begin
    int v_idx;
    w_any_cand = 1'b0;
    w_winner   = '0;
    v_idx      = 0;
    for (int k = int'(NUM_IN) - 1; k >= 0; k--) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= int'(NUM_IN)) v_idx = v_idx - int'(NUM_IN);
      if (w_cand[CUR_W'(v_idx)]) begin
        w_any_cand = 1'b1;
        w_winner   = CUR_W'(v_idx);
      end
    end
  end

  assign w_cur       = (r_state == S_IDLE) ? w_winner : r_cur;
  assign w_granted   = (r_state == S_IDLE) ? w_any_cand : 1'b1;
  assign w_cur_valid = valid_in[w_cur];
  assign w_cur_tail  = tail_in[w_cur];
  assign w_cur_inc   = (w_cur == CUR_W'(NUM_IN - 1)) ? '0 : w_cur + CUR_W'(1);

  always_comb begin
    w_cur_flit = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (w_cur == CUR_W'(i)) w_cur_flit = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A head still owed after a credit stall only exists when killing is off, so IDLE marks every head.
  assign w_kill     = (KILL_HEADERS != 0) && (r_state == S_IDLE) && w_any_cand;
  assign w_send     = w_granted && w_cur_valid && ((r_credit_cnt != '0) || w_kill);
  assign w_fwd      = w_send && !w_kill;
  assign w_ec       = w_granted && w_cur_valid && (r_credit_cnt == '0) && !w_kill;
  assign w_len_zero = (w_cur_flit[LEN_LSB +: LEN_W] == '0);

  // Next-state logic for the grant lock and round-robin pointer.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_any_cand) begin
          w_cur_nxt = w_winner;
          if (w_send && w_cur_tail) w_rr_nxt = w_cur_inc;
          else                      w_state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (w_send && w_cur_tail) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = w_cur_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cur    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cur    <= w_cur_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Credit counter: simultaneous send and return cancel; returns at full count are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_credit_cnt <= CRED_W'(CREDITS);
    end else if (w_fwd && !yummy_in) begin
      r_credit_cnt <= r_credit_cnt - CRED_W'(1);
    end else if (!w_fwd && yummy_in && (r_credit_cnt != CRED_W'(CREDITS))) begin
      r_credit_cnt <= r_credit_cnt + CRED_W'(1);
    end
    if (reset && yummy_in && !w_fwd) begin
      assert (r_credit_cnt != CRED_W'(CREDITS))
        else $error("dynamic_output_rr_para: credit returned while credit count is full");
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_valid_out <= w_fwd;
      if (w_fwd) r_data_out <= w_cur_flit;
    end
  end

  assign thanks_out                  = (reset && w_send) ? (NUM_IN'(1) << w_cur) : '0;
  assign popped_zero_len_mesg_out    = reset && w_send && w_kill && w_len_zero;
  assign ec_wants_to_send_but_cannot = reset && w_ec;
  assign valid_out                   = r_valid_out;
  assign data_out                    = r_data_out;

`ifdef DYNAMIC_OUTPUT_PERF_CNT_EN
  logic [15:0] r_perf_flits;
  logic [15:0] r_perf_stall;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_flits <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_fwd && (r_perf_flits != 16'hFFFF)) r_perf_flits <= r_perf_flits + 16'd1;
      if (w_ec && (r_perf_stall != 16'hFFFF))  r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_flits_out = r_perf_flits;
  assign perf_stall_out = r_perf_stall;
`else
  assign perf_flits_out = '0;
  assign perf_stall_out = '0;
`endif

endmodule

// File: tb/tb_dynamic_output_rr_para.sv
// Directed bench for dynamic_output_rr_para: one forwarding instance and one header-kill instance.
module tb_dynamic_output_rr_para;

  logic         clk;
  logic         reset;
  logic [4:0]   route_req, tail, valid;
  logic [319:0] data;
  logic         yummy;
  logic [4:0]   thanks;
  logic         vout, popped, ec;
  logic [63:0]  dout;
  logic [15:0]  pf, ps;

  logic [4:0]   k_route, k_tail, k_valid;
  logic [319:0] k_data;
  logic         k_yummy;
  logic [4:0]   k_thanks;
  logic         k_vout, k_popped, k_ec;
  logic [63:0]  k_dout;
  logic [15:0]  k_pf, k_ps;

  int n_chk = 0;
  int n_err = 0;

  dynamic_output_rr_para #(.NUM_IN(5), .DATA_WIDTH(64), .CREDITS(4), .KILL_HEADERS(0)) dut (
    .clk(clk), .reset(reset), .route_req_in(route_req), .tail_in(tail), .valid_in(valid),
    .data_in(data), .yummy_in(yummy), .thanks_out(thanks), .valid_out(vout), .data_out(dout),
    .popped_zero_len_mesg_out(popped), .ec_wants_to_send_but_cannot(ec),
    .perf_flits_out(pf), .perf_stall_out(ps));

  dynamic_output_rr_para #(.NUM_IN(5), .DATA_WIDTH(64), .CREDITS(4), .KILL_HEADERS(1)) dutk (
    .clk(clk), .reset(reset), .route_req_in(k_route), .tail_in(k_tail), .valid_in(k_valid),
    .data_in(k_data), .yummy_in(k_yummy), .thanks_out(k_thanks), .valid_out(k_vout), .data_out(k_dout),
    .popped_zero_len_mesg_out(k_popped), .ec_wants_to_send_but_cannot(k_ec),
    .perf_flits_out(k_pf), .perf_stall_out(k_ps));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    route_req = '0; tail = '0; valid = '0; yummy = 1'b0;
  endtask

  task automatic put(input int ch, input bit rq, input bit tl, input logic [63:0] d);
    route_req[ch] = rq; valid[ch] = 1'b1; tail[ch] = tl; data[ch*64 +: 64] = d;
  endtask

  task automatic kput(input int ch, input bit rq, input bit tl, input logic [63:0] d);
    k_route[ch] = rq; k_valid[ch] = 1'b1; k_tail[ch] = tl; k_data[ch*64 +: 64] = d;
  endtask

  initial begin
    reset = 1'b0; data = '0; clr();
    k_route = '0; k_tail = '0; k_valid = '0; k_data = '0; k_yummy = 1'b0;

    // Reset state, with a request present that must not be thanked
    cyc(); put(2, 1'b1, 1'b0, 64'hDEAD);
    cyc(); #1;
    chk("rst_thanks", 64'(thanks), 64'h0);
    chk("rst_vout", 64'(vout), 64'h0);
    chk("rst_dout", dout, 64'h0);
    chk("rst_credit", 64'(dut.r_credit_cnt), 64'd4);
    chk("rst_rr", 64'(dut.r_rr_ptr), 64'd0);
    chk("rst_k_thanks", 64'(k_thanks), 64'h0);
    cyc(); reset = 1'b1; clr();

    // Single 3-flit packet on ch2
    cyc(); put(2, 1'b1, 1'b0, 64'h2A); #1;
    chk("p1_thanks0", 64'(thanks), 64'b00100);
    cyc(); put(2, 1'b0, 1'b0, 64'h2B); #1;
    chk("p1_thanks1", 64'(thanks), 64'b00100);
    chk("p1_vout1", 64'(vout), 64'h1);
    chk("p1_dout1", dout, 64'h2A);
    cyc(); put(2, 1'b0, 1'b1, 64'h2C); #1;
    chk("p1_thanks2", 64'(thanks), 64'b00100);
    chk("p1_dout2", dout, 64'h2B);
    cyc(); clr(); #1;
    chk("p1_thanks_idle", 64'(thanks), 64'h0);
    chk("p1_vout3", 64'(vout), 64'h1);
    chk("p1_dout3", dout, 64'h2C);
    chk("p1_credit", 64'(dut.r_credit_cnt), 64'd1);
    chk("p1_rr", 64'(dut.r_rr_ptr), 64'd3);
    cyc(); yummy = 1'b1; #1;
    chk("p1_vout_low", 64'(vout), 64'h0);
    chk("p1_dout_hold", dout, 64'h2C);
    cyc(); cyc(); cyc(); yummy = 1'b0; #1;
    chk("p1_credit_back", 64'(dut.r_credit_cnt), 64'd4);

    // Round robin from rr_ptr=0: ch0 fully, then ch3
    cyc(); reset = 1'b0;
    cyc(); reset = 1'b1;
    cyc(); put(0, 1'b1, 1'b0, 64'h100); put(3, 1'b1, 1'b0, 64'h300); #1;
    chk("rr_thanks_a", 64'(thanks), 64'b00001);
    cyc(); put(0, 1'b0, 1'b1, 64'h101); #1;
    chk("rr_thanks_b", 64'(thanks), 64'b00001);
    chk("rr_dout_b", dout, 64'h100);
    cyc(); valid[0] = 1'b0; tail[0] = 1'b0; #1;
    chk("rr_thanks_c", 64'(thanks), 64'b01000);
    chk("rr_dout_c", dout, 64'h101);
    chk("rr_ptr_c", 64'(dut.r_rr_ptr), 64'd1);
    cyc(); put(3, 1'b0, 1'b1, 64'h301); #1;
    chk("rr_thanks_d", 64'(thanks), 64'b01000);
    chk("rr_dout_d", dout, 64'h300);
    cyc(); clr(); #1;
    chk("rr_dout_e", dout, 64'h301);
    chk("rr_ptr_e", 64'(dut.r_rr_ptr), 64'd4);
    chk("rr_credit_e", 64'(dut.r_credit_cnt), 64'd0);
    cyc(); yummy = 1'b1;
    cyc(); cyc(); cyc(); cyc(); yummy = 1'b0; #1;
    chk("rr_credit_back", 64'(dut.r_credit_cnt), 64'd4);

    // 6-flit packet on ch1 against 4 credits; ch0 request must be ignored while locked
    for (int f = 1; f <= 4; f++) begin
      cyc(); put(1, (f == 1), 1'b0, 64'(64'h10 + 64'(f))); #1;
      chk("cs_thanks", 64'(thanks), 64'b00010);
    end
    cyc(); put(1, 1'b0, 1'b0, 64'h15); put(0, 1'b1, 1'b0, 64'h99); #1;
    chk("cs_stall_thanks", 64'(thanks), 64'h0);
    chk("cs_stall_ec", 64'(ec), 64'h1);
    chk("cs_stall_dout", dout, 64'h14);
    chk("cs_stall_credit", 64'(dut.r_credit_cnt), 64'd0);
    cyc(); yummy = 1'b1; #1;
    chk("cs_y_thanks", 64'(thanks), 64'h0);
    chk("cs_y_ec", 64'(ec), 64'h1);
    cyc(); yummy = 1'b0; #1;
    chk("cs_one_thanks", 64'(thanks), 64'b00010);
    chk("cs_one_ec", 64'(ec), 64'h0);
    cyc(); put(1, 1'b0, 1'b1, 64'h16); #1;
    chk("cs_again_thanks", 64'(thanks), 64'h0);
    chk("cs_again_ec", 64'(ec), 64'h1);
    chk("cs_f5_vout", 64'(vout), 64'h1);
    chk("cs_f5_dout", dout, 64'h15);
    cyc(); yummy = 1'b1; #1;
    chk("cs_gap_vout", 64'(vout), 64'h0);
    chk("cs_gap_thanks", 64'(thanks), 64'h0);
    cyc(); yummy = 1'b0; #1;
    chk("cs_tail_thanks", 64'(thanks), 64'b00010);
    cyc(); clr(); #1;
    chk("cs_f6_dout", dout, 64'h16);
    chk("cs_f6_credit", 64'(dut.r_credit_cnt), 64'd0);
    cyc(); yummy = 1'b1;
    cyc();
    cyc(); put(4, 1'b1, 1'b1, 64'h44); #1;
    chk("sy_credit_pre", 64'(dut.r_credit_cnt), 64'd2);
    chk("sy_thanks", 64'(thanks), 64'b10000);
    cyc(); clr(); #1;
    chk("sy_credit_post", 64'(dut.r_credit_cnt), 64'd2);
    chk("sy_dout", dout, 64'h44);
    cyc(); yummy = 1'b1;
    cyc();
    cyc(); clr(); #1;
    chk("sy_credit_back", 64'(dut.r_credit_cnt), 64'd4);

    // Reset mid-packet on ch1
    cyc(); put(1, 1'b1, 1'b0, 64'h51); #1;
    chk("mr_thanks", 64'(thanks), 64'b00010);
    cyc(); put(1, 1'b0, 1'b0, 64'h52); reset = 1'b0; #1;
    chk("mr_thanks_in_rst", 64'(thanks), 64'h0);
    cyc(); reset = 1'b1; put(3, 1'b1, 1'b1, 64'h33); #1;
    chk("mr_vout", 64'(vout), 64'h0);
    chk("mr_credit", 64'(dut.r_credit_cnt), 64'd4);
    chk("mr_pf", 64'(pf), 64'h0);
    chk("mr_ps", 64'(ps), 64'h0);
    chk("mr_unlocked_thanks", 64'(thanks), 64'b01000);
    cyc(); clr(); #1;
    chk("mr_dout", dout, 64'h33);

    // Header-kill instance
    cyc(); kput(0, 1'b1, 1'b1, 64'hABCD_0000_0000_1234); #1;
    chk("k_thanks0", 64'(k_thanks), 64'b00001);
    chk("k_popped0", 64'(k_popped), 64'h1);
    cyc(); k_valid = '0; k_route = '0; k_tail = '0;
    kput(2, 1'b1, 1'b0, 64'h0000_0000_0140_0000); #1;
    chk("k_vout_after_kill", 64'(k_vout), 64'h0);
    chk("k_credit_after_kill", 64'(dutk.r_credit_cnt), 64'd4);
    chk("k_thanks1", 64'(k_thanks), 64'b00100);
    chk("k_popped1", 64'(k_popped), 64'h0);
    cyc(); kput(2, 1'b0, 1'b1, 64'h77); #1;
    chk("k_thanks2", 64'(k_thanks), 64'b00100);
    chk("k_popped2", 64'(k_popped), 64'h0);
    chk("k_vout_hdr", 64'(k_vout), 64'h0);
    cyc(); k_valid = '0; k_route = '0; k_tail = '0; #1;
    chk("k_vout_body", 64'(k_vout), 64'h1);
    chk("k_dout_body", k_dout, 64'h77);
    chk("k_credit_body", 64'(dutk.r_credit_cnt), 64'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
